// File: rtl/uart_periph_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_periph_if
//  Description : Memory-mapped bus link between the system bus mux and the
//                UART peripheral.
//                  uart_valid  request, already address-qualified (mux -> uart)
//                  uart_addr   byte address                          (mux -> uart)
//                  uart_wdata  write data                            (mux -> uart)
//                  uart_wstrb  byte strobes, 0 = read                (mux -> uart)
//                  uart_ready  one-cycle acknowledge                 (uart -> mux)
//                  uart_rdata  read data, valid with uart_ready      (uart -> mux)
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_periph_if;
    logic        uart_valid;
    logic [31:0] uart_addr;
    logic [31:0] uart_wdata;
    logic [3:0]  uart_wstrb;
    logic        uart_ready;
    logic [31:0] uart_rdata;

    modport master (
        output uart_valid, uart_addr, uart_wdata, uart_wstrb,
        input  uart_ready, uart_rdata
    );

    modport slave (
        input  uart_valid, uart_addr, uart_wdata, uart_wstrb,
        output uart_ready, uart_rdata
    );
endinterface
`default_nettype wire

// File: rtl/uart_periph.sv
`default_nettype none
// ============================================================================
//  Module      : uart_periph
//  Description : Memory-mapped UART with TX FIFO, single-entry RX holding
//                register and programmable baud divisor.
//  Ports       : clk      system clock
//                resetn   asynchronous active-low reset
//                bus      uart_periph_if.slave (valid/addr/wdata/wstrb in,
//                         ready/rdata out)
//                uart_tx  serial output, idle high
//                uart_rx  serial input, asynchronous to clk
//  Registers   : 0 DATA, 1 STATUS, 2 DIV, 3 CTRL (selected by addr[3:2])
//  Options     : UART_LOOPBACK_EN - when defined, CTRL bit0 routes uart_tx
//                into the RX synchronizer.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_periph #(
    parameter int DEFAULT_DIV   = 104,
    parameter int TX_FIFO_DEPTH = 16
) (
    input  wire          clk,
    input  wire          resetn,
    uart_periph_if.slave bus,
    output logic         uart_tx,
    input  wire          uart_rx
);

    localparam int          c_aw          = $clog2(TX_FIFO_DEPTH);
    localparam logic [15:0] c_default_div = 16'(DEFAULT_DIV);
    localparam logic [15:0] c_min_div     = 16'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Bus decode. All side effects are qualified with the acknowledge
    // cycle so a held request acts exactly once.
    // ------------------------------------------------------------------
    logic       ready_q, ready_d;
    logic       w_ack;
    logic [1:0] w_reg;
    logic       w_is_write;
    logic       w_data_wr, w_data_rd, w_stat_rd, w_div_wr, w_ctrl_wr;

    assign ready_d    = bus.uart_valid && !ready_q;
    assign w_ack      = ready_q && bus.uart_valid;
    assign w_reg      = bus.uart_addr[3:2];
    assign w_is_write = |bus.uart_wstrb;
    assign w_data_wr  = w_ack && (w_reg == 2'd0) && bus.uart_wstrb[0];
    assign w_data_rd  = w_ack && (w_reg == 2'd0) && !w_is_write;
    assign w_stat_rd  = w_ack && (w_reg == 2'd1) && !w_is_write;
    assign w_div_wr   = w_ack && (w_reg == 2'd2) && (|bus.uart_wstrb[1:0]);
    assign w_ctrl_wr  = w_ack && (w_reg == 2'd3) && bus.uart_wstrb[0];

    // ------------------------------------------------------------------
    // Divisor register
    // ------------------------------------------------------------------
    logic [15:0] div_q, div_d;
    logic [15:0] w_div_new;

    always_comb begin
        w_div_new = div_q;
        if (bus.uart_wstrb[0]) w_div_new[7:0]  = bus.uart_wdata[7:0];
        if (bus.uart_wstrb[1]) w_div_new[15:8] = bus.uart_wdata[15:8];
        div_d = div_q;
        if (w_div_wr) div_d = (w_div_new < c_min_div) ? c_min_div : w_div_new;
    end

    // ------------------------------------------------------------------
    // Control register / loopback select
    // ------------------------------------------------------------------
    logic w_loopback;
    logic w_rx_in;
`ifdef UART_LOOPBACK_EN
    logic loopback_q, loopback_d;
    assign loopback_d = w_ctrl_wr ? bus.uart_wdata[0] : loopback_q;
    assign w_loopback = loopback_q;
    assign w_rx_in    = loopback_q ? uart_tx : uart_rx;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) loopback_q <= 1'b0;
        else         loopback_q <= loopback_d;
    end
`else
    logic w_ctrl_unused;
    assign w_ctrl_unused = w_ctrl_wr;
    assign w_loopback    = 1'b0;
    assign w_rx_in       = uart_rx;
`endif

    // ------------------------------------------------------------------
    // TX FIFO. Extra pointer MSB separates full from empty.
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
    logic [c_aw:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          w_fifo_empty, w_fifo_full;
    logic          w_tx_pop, w_push, w_drop;
    logic [7:0]    w_fifo_rdata;

    assign w_fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign w_fifo_full  = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                          (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
    assign w_fifo_rdata = fifo_mem[rd_ptr_q[c_aw-1:0]];
    // A pop in the same cycle frees a slot, so a push while full still lands.
    assign w_push   = w_data_wr && (!w_fifo_full || w_tx_pop);
    assign w_drop   = w_data_wr && w_fifo_full && !w_tx_pop;
    assign wr_ptr_d = w_push   ? wr_ptr_q + {{c_aw{1'b0}}, 1'b1} : wr_ptr_q;
    assign rd_ptr_d = w_tx_pop ? rd_ptr_q + {{c_aw{1'b0}}, 1'b1} : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (w_push) fifo_mem[wr_ptr_q[c_aw-1:0]] <= bus.uart_wdata[7:0];
    end

    // ------------------------------------------------------------------
    // TX state machine. The counter reloads from div_q at every bit
    // boundary, so a divisor change lands on the next bit.
    // ------------------------------------------------------------------
    state_t      tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_line_q, tx_line_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        w_tx_pop   = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                tx_line_d = 1'b1;
                if (!w_fifo_empty) begin
                    w_tx_pop   = 1'b1;
                    tx_shift_d = w_fifo_rdata;
                    tx_cnt_d   = div_q - 16'd1;
                    tx_line_d  = 1'b0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d   = div_q - 16'd1;
                    tx_bit_d   = 3'd0;
                    tx_line_d  = tx_shift_q[0];
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d = div_q - 16'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == 16'd0) begin
                    // Chain straight into the next start bit when data waits.
                    if (!w_fifo_empty) begin
                        w_tx_pop   = 1'b1;
                        tx_shift_d = w_fifo_rdata;
                        tx_cnt_d   = div_q - 16'd1;
                        tx_line_d  = 1'b0;
                        tx_state_d = ST_START;
                    end else begin
                        tx_line_d  = 1'b1;
                        tx_state_d = ST_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    assign uart_tx = tx_line_q;

    // ------------------------------------------------------------------
    // RX synchronizer and state machine
    // ------------------------------------------------------------------
    logic        rx_sync1_q, rx_sync2_q, rx_prev_q;
    state_t      rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        w_rx_deliver, w_frame_evt;

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        w_rx_deliver = 1'b0;
        w_frame_evt  = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_sync2_q) begin
                    rx_cnt_d   = (div_q >> 1) - 16'd1;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt_q == 16'd0) begin
                    if (rx_sync2_q) begin
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_cnt_d   = div_q - 16'd1;
                        rx_bit_d   = 3'd0;
                        rx_state_d = ST_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    rx_cnt_d   = div_q - 16'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_state_d   = ST_IDLE;
                    w_rx_deliver = rx_sync2_q;
                    w_frame_evt  = !rx_sync2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // RX holding register and sticky status
    // ------------------------------------------------------------------
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       overrun_q, overrun_d, drop_q, drop_d, frame_q, frame_d;
    logic       w_rx_pop, w_overrun_evt;

    assign w_rx_pop      = w_data_rd && rx_valid_q;
    assign w_overrun_evt = w_rx_deliver && rx_valid_q && !w_rx_pop;

    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_byte_d  = rx_byte_q;
        if (w_rx_pop) rx_valid_d = 1'b0;
        if (w_rx_deliver && (!rx_valid_q || w_rx_pop)) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = rx_shift_q;
        end
        // Status-read clear loses against an event in the same cycle.
        overrun_d = (w_stat_rd ? 1'b0 : overrun_q) | w_overrun_evt;
        drop_d    = (w_stat_rd ? 1'b0 : drop_q)    | w_drop;
        frame_d   = (w_stat_rd ? 1'b0 : frame_q)   | w_frame_evt;
    end

    // ------------------------------------------------------------------
    // Read data, presented combinationally during the acknowledge cycle
    // so it reflects exactly the state the side effects act on.
    // ------------------------------------------------------------------
    logic [31:0] w_rd_mux;

    always_comb begin
        w_rd_mux = 32'd0;
        case (w_reg)
            2'd0: w_rd_mux = rx_valid_q ? {23'd0, 1'b1, rx_byte_q} : 32'd0;
            2'd1: w_rd_mux = {25'd0, frame_q, drop_q, overrun_q, rx_valid_q,
                              (tx_state_q != ST_IDLE), w_fifo_empty, w_fifo_full};
            2'd2: w_rd_mux = {16'd0, div_q};
            2'd3: w_rd_mux = {31'd0, w_loopback};
            default: w_rd_mux = 32'd0;
        endcase
    end

    assign bus.uart_ready = ready_q;
    assign bus.uart_rdata = ready_q ? w_rd_mux : 32'd0;

    logic w_unused;
    assign w_unused = ^{bus.uart_addr[31:4], bus.uart_addr[1:0],
                        bus.uart_wdata[31:16], bus.uart_wstrb[3:2]};

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q    <= 1'b0;
            div_q      <= c_default_div;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'd0;
            tx_line_q  <= 1'b1;
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
            rx_valid_q <= 1'b0;
            rx_byte_q  <= 8'd0;
            overrun_q  <= 1'b0;
            drop_q     <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            div_q      <= div_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            rx_sync1_q <= w_rx_in;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            rx_byte_q  <= rx_byte_d;
            overrun_q  <= overrun_d;
            drop_q     <= drop_d;
            frame_q    <= frame_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_periph.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_periph
//  Description : Directed self-checking bench for uart_periph. Build with
//                UART_LOOPBACK_EN defined to exercise the loopback path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_periph;

    localparam logic [31:0] c_a_data = 32'h2000_0000;
    localparam logic [31:0] c_a_stat = 32'h2000_0004;
    localparam logic [31:0] c_a_div  = 32'h2000_0008;
    localparam logic [31:0] c_a_ctrl = 32'h2000_000C;

    logic clk = 1'b0;
    logic resetn;
    logic uart_tx;
    logic uart_rx;
    int   checks = 0;
    int   errors = 0;

    uart_periph_if bif ();

    uart_periph #(
        .DEFAULT_DIV   (104),
        .TX_FIFO_DEPTH (16)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .bus     (bif.slave),
        .uart_tx (uart_tx),
        .uart_rx (uart_rx)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // One bus transaction; lat = posedges from request to ready (0 = timeout).
    task automatic bus_access(input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ws, output logic [31:0] rd,
                              output int lat);
        lat = 0;
        rd  = 32'd0;
        @(negedge clk);
        bif.uart_valid = 1'b1;
        bif.uart_addr  = a;
        bif.uart_wdata = wd;
        bif.uart_wstrb = ws;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (bif.uart_ready) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_timeout addr=%h got no ready, required ready", a);
        end else begin
            rd = bif.uart_rdata;
        end
        @(posedge clk);
        #1;
        bif.uart_valid = 1'b0;
        bif.uart_wstrb = 4'd0;
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
        int l;
        bus_access(a, 32'd0, 4'd0, d, l);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] d;
        int l;
        bus_access(a, wd, ws, d, l);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (16) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (16) @(negedge clk);
        uart_rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        int lat;
        bif.uart_valid = 1'b0;
        bif.uart_addr  = 32'd0;
        bif.uart_wdata = 32'd0;
        bif.uart_wstrb = 4'd0;
        uart_rx = 1'b1;
        resetn  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (uart_tx !== 1'b1 || bif.uart_ready !== 1'b0 || bif.uart_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got tx=%b ready=%b rdata=%h required 1 0 0",
                     uart_tx, bif.uart_ready, bif.uart_rdata);
        end
        @(negedge clk);
        resetn = 1'b1;
        bus_access(c_a_stat, 32'd0, 4'd0, d, lat);
        checks++;
        if (d !== 32'h0000_0002) begin
            errors++; $display("FAIL reset_status got=%h required=%h", d, 32'h2);
        end
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL ready_latency got=%0d required=1", lat);
        end
        checks++;
        if (bif.uart_ready !== 1'b0) begin
            errors++; $display("FAIL ready_one_cycle got=%b required=0", bif.uart_ready);
        end
        rd_reg(c_a_div, d);
        checks++;
        if (d !== 32'd104) begin
            errors++; $display("FAIL reset_div got=%h required=%h", d, 32'd104);
        end
    endtask

    task automatic test_div;
        logic [31:0] d;
        wr_reg(c_a_div, 32'hFFFF_0002, 4'b1111);
        rd_reg(c_a_div, d);
        checks++;
        if (d !== 32'h0000_0004) begin
            errors++; $display("FAIL div_clamp got=%h required=%h", d, 32'h4);
        end
        wr_reg(c_a_div, 32'h0000_0110, 4'b0001);
        rd_reg(c_a_div, d);
        checks++;
        if (d !== 32'h0000_0010) begin
            errors++; $display("FAIL div_low_strobe got=%h required=%h", d, 32'h10);
        end
        wr_reg(c_a_div, 32'h0000_0800, 4'b0010);
        rd_reg(c_a_div, d);
        checks++;
        if (d !== 32'h0000_0810) begin
            errors++; $display("FAIL div_high_strobe got=%h required=%h", d, 32'h810);
        end
        wr_reg(c_a_div, 32'h0000_0008, 4'b0011);
    endtask

    task automatic test_tx_frame;
        logic [31:0] d;
        int lat, s, bad;
        logic samp [200];
        logic [9:0] fr;
        fr = {1'b1, 8'hA5, 1'b0};
        wr_reg(c_a_data, 32'h0000_00A5, 4'b0001);
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    samp[i] = uart_tx;
                end
            end
            begin
                bus_access(c_a_stat, 32'd0, 4'd0, d, lat);
            end
        join
        checks++;
        if (d !== 32'h0000_0006) begin
            errors++; $display("FAIL tx_busy_status got=%h required=%h", d, 32'h6);
        end
        s = -1;
        for (int i = 0; i < 100; i++) if (s < 0 && samp[i] == 1'b0) s = i;
        checks++;
        if (s < 0) begin
            errors++; $display("FAIL tx_start_found got=none required=start bit");
        end else begin
            for (int b = 0; b < 10; b++) begin
                bad = 0;
                for (int c = 0; c < 8; c++) if (samp[s + 8*b + c] !== fr[b]) bad++;
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL tx_bit%0d got %0d wrong cycles, required level %b for 8 cycles",
                             b, bad, fr[b]);
                end
            end
            bad = 0;
            for (int c = 80; c < 90; c++) if (samp[s + c] !== 1'b1) bad++;
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL tx_idle_after got %0d low cycles, required 0", bad);
            end
        end
        rd_reg(c_a_stat, d);
        checks++;
        if (d !== 32'h0000_0002) begin
            errors++; $display("FAIL tx_done_status got=%h required=%h", d, 32'h2);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d1, d2, d3, d;
        int s, bad;
        logic samp [800];
        logic [9:0] fr;
        wr_reg(c_a_div, 32'h0000_0004, 4'b0011);
        fork
            begin
                for (int i = 0; i < 800; i++) begin
                    @(negedge clk);
                    samp[i] = uart_tx;
                end
            end
            begin
                // One byte leaves the FIFO at once, so 17 writes fill it.
                for (int k = 0; k < 17; k++) wr_reg(c_a_data, 32'h10 + k, 4'b0001);
                rd_reg(c_a_stat, d1);
                wr_reg(c_a_data, 32'h0000_0021, 4'b0001);
                rd_reg(c_a_stat, d2);
                rd_reg(c_a_stat, d3);
            end
        join
        checks++;
        if (d1 !== 32'h0000_0005) begin
            errors++; $display("FAIL fifo_full_status got=%h required=%h", d1, 32'h5);
        end
        checks++;
        if (d2 !== 32'h0000_0025) begin
            errors++; $display("FAIL tx_drop_status got=%h required=%h", d2, 32'h25);
        end
        checks++;
        if (d3[5] !== 1'b0) begin
            errors++; $display("FAIL tx_drop_cleared got=%b required=0", d3[5]);
        end
        s = -1;
        for (int i = 0; i < 40; i++) if (s < 0 && samp[i] == 1'b0) s = i;
        checks++;
        if (s < 0) begin
            errors++; $display("FAIL b2b_start_found got=none required=start bit");
        end else begin
            for (int f = 0; f < 17; f++) begin
                fr = {1'b1, 8'(8'h10 + f), 1'b0};
                bad = 0;
                for (int k = 0; k < 40; k++) if (samp[s + 40*f + k] !== fr[k/4]) bad++;
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL b2b_frame%0d got %0d wrong cycles, required byte %h gapless",
                             f, bad, 8'(8'h10 + f));
                end
            end
            bad = 0;
            for (int k = 680; k < 700; k++) if (samp[s + k] !== 1'b1) bad++;
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL b2b_dropped_not_sent got %0d low cycles, required 0", bad);
            end
        end
        rd_reg(c_a_stat, d);
        checks++;
        if (d !== 32'h0000_0002) begin
            errors++; $display("FAIL b2b_drained got=%h required=%h", d, 32'h2);
        end
    endtask

    task automatic test_rx;
        logic [31:0] d;
        wr_reg(c_a_div, 32'h0000_0010, 4'b0011);
        send_rx(8'h3C, 1'b1);
        rd_reg(c_a_stat, d);
        checks++;
        if (d !== 32'h0000_000A) begin
            errors++; $display("FAIL rx_valid_status got=%h required=%h", d, 32'hA);
        end
        rd_reg(c_a_data, d);
        checks++;
        if (d !== 32'h0000_013C) begin
            errors++; $display("FAIL rx_data got=%h required=%h", d, 32'h13C);
        end
        rd_reg(c_a_data, d);
        checks++;
        if (d !== 32'h0000_0000) begin
            errors++; $display("FAIL rx_data_empty got=%h required=%h", d, 32'h0);
        end
    endtask

    task automatic test_rx_errors;
        logic [31:0] d;
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        rd_reg(c_a_stat, d);
        checks++;
        if (d !== 32'h0000_001A) begin
            errors++; $display("FAIL rx_overrun_status got=%h required=%h", d, 32'h1A);
        end
        rd_reg(c_a_data, d);
        checks++;
        if (d !== 32'h0000_0111) begin
            errors++; $display("FAIL rx_overrun_keeps_first got=%h required=%h", d, 32'h111);
        end
        rd_reg(c_a_stat, d);
        checks++;
        if (d !== 32'h0000_0002) begin
            errors++; $display("FAIL rx_overrun_cleared got=%h required=%h", d, 32'h2);
        end
        send_rx(8'h44, 1'b1);
        send_rx(8'h55, 1'b0);
        rd_reg(c_a_stat, d);
        checks++;
        if (d !== 32'h0000_004A) begin
            errors++; $display("FAIL rx_frame_err_status got=%h required=%h", d, 32'h4A);
        end
        rd_reg(c_a_data, d);
        checks++;
        if (d !== 32'h0000_0144) begin
            errors++; $display("FAIL rx_frame_err_byte got=%h required=%h", d, 32'h144);
        end
        rd_reg(c_a_stat, d);
        checks++;
        if (d !== 32'h0000_0002) begin
            errors++; $display("FAIL rx_frame_err_cleared got=%h required=%h", d, 32'h2);
        end
    endtask

`ifdef UART_LOOPBACK_EN
    task automatic test_loopback;
        logic [31:0] d;
        wr_reg(c_a_ctrl, 32'h0000_0001, 4'b0001);
        rd_reg(c_a_ctrl, d);
        checks++;
        if (d !== 32'h0000_0001) begin
            errors++; $display("FAIL ctrl_loopback_rd got=%h required=%h", d, 32'h1);
        end
        wr_reg(c_a_div, 32'h0000_0004, 4'b0011);
        wr_reg(c_a_data, 32'h0000_005A, 4'b0001);
        repeat (80) @(negedge clk);
        rd_reg(c_a_stat, d);
        checks++;
        if (d !== 32'h0000_000A) begin
            errors++; $display("FAIL loopback_status got=%h required=%h", d, 32'hA);
        end
        rd_reg(c_a_data, d);
        checks++;
        if (d !== 32'h0000_015A) begin
            errors++; $display("FAIL loopback_data got=%h required=%h", d, 32'h15A);
        end
        wr_reg(c_a_ctrl, 32'h0000_0000, 4'b0001);
    endtask
`else
    task automatic test_ctrl;
        logic [31:0] d;
        wr_reg(c_a_ctrl, 32'hFFFF_FFFF, 4'b1111);
        rd_reg(c_a_ctrl, d);
        checks++;
        if (d !== 32'h0000_0000) begin
            errors++; $display("FAIL ctrl_reads_zero got=%h required=%h", d, 32'h0);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_div;
        test_tx_frame;
        test_back_to_back;
        test_rx;
        test_rx_errors;
`ifdef UART_LOOPBACK_EN
        test_loopback;
`else
        test_ctrl;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
